// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators with in-place ALU ops, carry/zero flags and a
// shared LIFO save stack used for context save around subroutine calls.
module accumulator_bank #(
    parameter int WIDTH       = 8,
    parameter int NUM_ACC     = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SEL_W       = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [SEL_W-1:0] sel,
    input  logic [2:0]       op,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] DataOut,
    output logic             carry,
    output logic             zero,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [SEL_W:0]  ACC_LIMIT = (SEL_W + 1)'(NUM_ACC);
    localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } op_t;

    // Architectural state
    logic [WIDTH-1:0] acc_q [NUM_ACC];
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    // Next-state datapath signals
    logic             sel_valid;
    logic [WIDTH-1:0] acc_sel;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             push_we;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [NUM_ACC-1:0] acc_we;

    assign sel_valid = ({1'b0, sel} < ACC_LIMIT);
    assign acc_sel   = sel_valid ? acc_q[sel] : '0;
    assign wr_idx    = AW'(sp_q);
    assign rd_idx    = AW'(sp_q - SP_W'(1));
    assign sum       = {1'b0, acc_sel} + {1'b0, DataIn};
    assign diff      = {1'b0, acc_sel} - {1'b0, DataIn};

    always_comb begin
        wr_en   = 1'b0;
        wr_data = acc_sel;
        carry_d = carry_q;
        zero_d  = zero_q;
        sp_d    = sp_q;
        err_d   = 1'b0;
        push_we = 1'b0;

        if (clr) begin
            // clr beats any concurrent op; an out-of-range sel turns it into an error
            if (sel_valid) begin
                wr_en   = 1'b1;
                wr_data = '0;
                carry_d = 1'b0;
                zero_d  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
            if (!sel_valid) begin
                err_d = 1'b1;
            end else begin
                unique case (op_t'(op))
                    OP_NOP: ;
                    OP_LOAD: begin
                        wr_en   = 1'b1;
                        wr_data = DataIn;
                    end
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_SUB: begin
                        // bit WIDTH of the widened difference is the unsigned borrow
                        wr_en   = 1'b1;
                        wr_data = diff[WIDTH-1:0];
                        carry_d = diff[WIDTH];
                    end
                    OP_SHL: begin
                        wr_en   = 1'b1;
                        wr_data = {acc_sel[WIDTH-2:0], 1'b0};
                        carry_d = acc_sel[WIDTH-1];
                    end
                    OP_SHR: begin
                        wr_en   = 1'b1;
                        wr_data = {1'b0, acc_sel[WIDTH-1:1]};
                        carry_d = acc_sel[0];
                    end
                    OP_PUSH: begin
                        if (sp_q == SP_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            push_we = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                        end
                    end
                    OP_POP: begin
                        if (sp_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_data = stack_mem[rd_idx];
                            sp_d    = sp_q - SP_W'(1);
                        end
                    end
                    default: ;
                endcase
                if (wr_en) begin
                    zero_d = (wr_data == '0);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACC; gi++) begin : g_acc_we
            assign acc_we[gi] = wr_en && (sel == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ACC; i++) begin
            if (rst) begin
                acc_q[i] <= '0;
            end else if (acc_we[i]) begin
                acc_q[i] <= wr_data;
            end
        end
    end

    // Stack storage is not reset; only the pointer defines what is valid
    always_ff @(posedge clk) begin
        if (!rst && push_we) begin
            stack_mem[wr_idx] <= acc_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign DataOut     = acc_sel;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign err         = err_q;
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_accumulator_bank;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] SHL  = 3'b100;
    localparam logic [2:0] SHR  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] DataIn;
    logic [1:0] sel;
    logic [2:0] op;
    logic       en;
    logic       clr;
    logic [7:0] DataOut;
    logic       carry;
    logic       zero;
    logic       stack_full;
    logic       stack_empty;
    logic       err;

    int tests_run = 0;
    int tests_failed = 0;

    accumulator_bank #(
        .WIDTH(8),
        .NUM_ACC(4),
        .STACK_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DataIn(DataIn),
        .sel(sel),
        .op(op),
        .en(en),
        .clr(clr),
        .DataOut(DataOut),
        .carry(carry),
        .zero(zero),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [1:0] s, input logic [2:0] o, input logic [7:0] d,
                        input logic e, input logic c);
        sel = s; op = o; DataIn = d; en = e; clr = c;
        @(posedge clk);
        #1;
        en = 1'b0; clr = 1'b0; op = NOP;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [1:0] s, input logic [7:0] exp);
        sel = s;
        #1;
        check(tag, DataOut, exp);
    endtask

    task automatic flags(input string tag, input logic c, input logic z, input logic e);
        check({tag, ".carry"}, {7'd0, carry}, {7'd0, c});
        check({tag, ".zero"},  {7'd0, zero},  {7'd0, z});
        check({tag, ".err"},   {7'd0, err},   {7'd0, e});
    endtask

    task automatic stk(input string tag, input logic f, input logic emp);
        check({tag, ".full"},  {7'd0, stack_full},  {7'd0, f});
        check({tag, ".empty"}, {7'd0, stack_empty}, {7'd0, emp});
    endtask

    initial begin
        rst = 1'b1; DataIn = '0; sel = '0; op = NOP; en = 1'b0; clr = 1'b0;
        idle();
        idle();
        rst = 1'b0;

        // 1: reset state
        for (int i = 0; i < 4; i++) peek($sformatf("rst.acc%0d", i), 2'(i), 8'h00);
        flags("rst", 1'b0, 1'b0, 1'b0);
        stk("rst", 1'b0, 1'b1);
        $display("[TB] reset checked");

        // 2: LOAD/ADD/SUB on acc0
        step(2'd0, LOAD, 8'hF0, 1'b1, 1'b0);
        check("load.acc0", DataOut, 8'hF0);
        flags("load", 1'b0, 1'b0, 1'b0);
        step(2'd0, ADD, 8'h20, 1'b1, 1'b0);
        check("add.acc0", DataOut, 8'h10);
        flags("add", 1'b1, 1'b0, 1'b0);
        step(2'd0, SUB, 8'h10, 1'b1, 1'b0);
        check("sub0.acc0", DataOut, 8'h00);
        flags("sub0", 1'b0, 1'b1, 1'b0);
        step(2'd0, SUB, 8'h01, 1'b1, 1'b0);
        check("subb.acc0", DataOut, 8'hFF);
        flags("subb", 1'b1, 1'b0, 1'b0);
        $display("[TB] load/add/sub checked");

        // hold: en=0 with an op present changes nothing
        step(2'd0, ADD, 8'h01, 1'b0, 1'b0);
        check("hold.acc0", DataOut, 8'hFF);
        flags("hold", 1'b1, 1'b0, 1'b0);

        // 3: shifts on acc1 (LOAD keeps carry=1 from the previous SUB)
        step(2'd1, LOAD, 8'h81, 1'b1, 1'b0);
        check("ld81.acc1", DataOut, 8'h81);
        flags("ld81", 1'b1, 1'b0, 1'b0);
        step(2'd1, SHL, 8'h00, 1'b1, 1'b0);
        check("shl.acc1", DataOut, 8'h02);
        flags("shl", 1'b1, 1'b0, 1'b0);
        step(2'd1, SHR, 8'h00, 1'b1, 1'b0);
        check("shr1.acc1", DataOut, 8'h01);
        flags("shr1", 1'b0, 1'b0, 1'b0);
        step(2'd1, SHR, 8'h00, 1'b1, 1'b0);
        check("shr2.acc1", DataOut, 8'h00);
        flags("shr2", 1'b1, 1'b1, 1'b0);
        peek("shr2.acc0_held", 2'd0, 8'hFF);
        $display("[TB] shifts checked");

        // 4: stack fill, overflow, drain, underflow
        for (int i = 0; i < 4; i++) step(2'(i), LOAD, 8'(i + 1), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'(i), PUSH, 8'h00, 1'b1, 1'b0);
            check($sformatf("push%0d.err", i), {7'd0, err}, 8'h00);
            check($sformatf("push%0d.full", i), {7'd0, stack_full}, (i == 3) ? 8'h01 : 8'h00);
        end
        flags("push.flags_held", 1'b1, 1'b0, 1'b0);
        step(2'd0, PUSH, 8'h00, 1'b1, 1'b0);
        check("ovf.err", {7'd0, err}, 8'h01);
        stk("ovf", 1'b1, 1'b0);
        idle();
        check("ovf.err_clear", {7'd0, err}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(2'd0, POP, 8'h00, 1'b1, 1'b0);
            check($sformatf("pop%0d.acc0", i), DataOut, 8'(4 - i));
            check($sformatf("pop%0d.err", i), {7'd0, err}, 8'h00);
        end
        stk("drained", 1'b0, 1'b1);
        step(2'd0, POP, 8'h00, 1'b1, 1'b0);
        check("unf.err", {7'd0, err}, 8'h01);
        check("unf.acc0", DataOut, 8'h01);
        stk("unf", 1'b0, 1'b1);
        idle();
        check("unf.err_clear", {7'd0, err}, 8'h00);
        $display("[TB] stack checked");

        // 5: clr wins over en+ADD; set carry first so the clear is visible
        step(2'd2, LOAD, 8'h55, 1'b1, 1'b0);
        step(2'd1, ADD, 8'hFF, 1'b1, 1'b0);
        check("pre_clr.acc1", DataOut, 8'h01);
        flags("pre_clr", 1'b1, 1'b0, 1'b0);
        step(2'd2, ADD, 8'h11, 1'b1, 1'b1);
        check("clr.acc2", DataOut, 8'h00);
        flags("clr", 1'b0, 1'b0, 1'b0);
        stk("clr", 1'b0, 1'b1);
        peek("clr.acc0", 2'd0, 8'h01);
        peek("clr.acc1", 2'd1, 8'h01);
        peek("clr.acc3", 2'd3, 8'h04);
        $display("[TB] clr checked");

        // 6: reset mid-sequence with a half-full stack
        step(2'd3, LOAD, 8'hAA, 1'b1, 1'b0);
        step(2'd3, PUSH, 8'h00, 1'b1, 1'b0);
        step(2'd3, PUSH, 8'h00, 1'b1, 1'b0);
        stk("half", 1'b0, 1'b0);
        rst = 1'b1;
        step(2'd3, ADD, 8'h01, 1'b1, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) peek($sformatf("rst2.acc%0d", i), 2'(i), 8'h00);
        flags("rst2", 1'b0, 1'b0, 1'b0);
        stk("rst2", 1'b0, 1'b1);
        step(2'd0, POP, 8'h00, 1'b1, 1'b0);
        check("rst2_pop.err", {7'd0, err}, 8'h01);
        check("rst2_pop.acc0", DataOut, 8'h00);
        $display("[TB] mid-sequence reset checked");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
